// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: default geometry, parameter check, full-adder cell and stage record for pipe_adder.
// Optional subtract support is controlled by PIPE_ADDER_SUB_EN.
package pipe_adder_pkg;
  localparam int PA_WIDTH  = 32;
  localparam int PA_STAGES = 4;
  function automatic bit pa_legal(input int width, input int stages);
    return stages > 0 && width % stages == 0;
  endfunction
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction
  // Stage record at the default geometry; the top re-declares it at its own WIDTH.
  typedef struct packed {
    logic                valid;
    logic [PA_WIDTH-1:0] psum;
    logic                carry;
    logic                ovf;
    logic [PA_WIDTH-1:0] a_rem;
    logic [PA_WIDTH-1:0] b_rem;
`ifdef PIPE_ADDER_SUB_EN
    logic                sub;
`endif
  } stage_t;
endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational W-bit ripple adder built from full-adder cells.
// Also reports the carry into the MSB so the final stage can form signed overflow (PIPE_ADDER_SUB_EN independent).
module adder_chunk
  import pipe_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o,
  output logic         c_msb_o
);
  logic cy;
  always_comb begin
    cy = c_i;
    c_msb_o = c_i;
    s_o = '0;
    for (int i = 0; i < W; i++) begin
      c_msb_o = cy;
      {cy, s_o[i]} = full_add(a_i[i], b_i[i], cy);
    end
    c_o = cy;
  end
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry adder, one CHUNK per stage, valid/ready on both sides.
// Define PIPE_ADDER_SUB_EN to add the sub input (a - b).
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = PA_WIDTH,
  parameter int STAGES = PA_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;
  if (!pa_legal(WIDTH, STAGES)) begin : g_bad
    $error("pipe_adder: STAGES must divide WIDTH exactly");
  end
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic             ovf;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
`ifdef PIPE_ADDER_SUB_EN
    logic             sub;
`endif
  } rec_t;
  rec_t in_rec;
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  always_comb begin
    in_rec = '0;
    in_rec.valid = in_valid;
    in_rec.a_rem = a;
    in_rec.b_rem = b;
`ifdef PIPE_ADDER_SUB_EN
    in_rec.sub = sub;
    in_rec.carry = sub | cin;
`else
    in_rec.carry = cin;
`endif
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    rec_t st_in, st_d, st_q;
    logic [CHUNK-1:0] cb, s;
    logic co, cm, unused_ok;
    if (k == 0) begin : g_first
      assign st_in = in_rec;
    end else begin : g_next
      assign st_in = g_stg[k-1].st_q;
    end
`ifdef PIPE_ADDER_SUB_EN
    assign cb = st_in.b_rem[k*CHUNK +: CHUNK] ^ {CHUNK{st_in.sub}};
`else
    assign cb = st_in.b_rem[k*CHUNK +: CHUNK];
`endif
    adder_chunk #(.W(CHUNK)) u_chunk (
      .a_i     (st_in.a_rem[k*CHUNK +: CHUNK]),
      .b_i     (cb),
      .c_i     (st_in.carry),
      .s_o     (s),
      .c_o     (co),
      .c_msb_o (cm)
    );
    // Consumed operand chunks and early-stage ovf bits are dead past this point.
    assign unused_ok = ^{st_in, st_q};
    always_comb begin
      st_d = st_in;
      st_d.psum[k*CHUNK +: CHUNK] = s;
      st_d.carry = co;
      st_d.ovf = cm ^ co;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st_q <= '0;
      else if (adv) st_q <= st_d;
  end
  assign out_valid = g_stg[STAGES-1].st_q.valid;
  assign sum       = g_stg[STAGES-1].st_q.psum;
  assign cout      = g_stg[STAGES-1].st_q.carry;
  assign ovf       = g_stg[STAGES-1].st_q.ovf;
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: vector table, hand sequences and randomized scoreboard run for pipe_adder.
// Sub-mode vectors are exercised when PIPE_ADDER_SUB_EN is defined.
module tb_pipe_adder;
  localparam int W = 32;
  localparam int S = 4;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, sub = 1'b0;
  logic in_ready, out_valid, cout, ovf;
  logic [W-1:0] a = '0, b = '0, sum;
  int checks = 0, errors = 0;
  logic [W+1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  bit collect = 1'b0;
  typedef struct {
    logic [W-1:0] a, b;
    logic         ci;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;
  vec_t vt[7];
  always #5 clk = ~clk;
  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef PIPE_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    logic [W-1:0] yy = sb ? ~y : y;
    logic [W:0] t = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, sb | ci};
    logic v = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {t[W], v, t[W-1:0]};
  endfunction
  task automatic chk(input string n, input longint g, input longint e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, g, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic one(input string n, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb,
                     input logic [W-1:0] es, input logic eco, input logic eov);
    int k = 0;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; sub = 1'b0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    chk({n, "_lat"}, longint'(k), longint'(S - 1));
    chk({n, "_sum"}, longint'(sum), longint'(es));
    chk({n, "_flags"}, longint'({cout, ovf}), longint'({eco, eov}));
  endtask
  always @(negedge clk) if (rst_n) begin
    if (out_valid && out_ready) begin
      if (collect) got_q.push_back(sum);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra got %0h want none", sum);
      end else chk("sb_result", longint'({cout, ovf, sum}), longint'(exp_q.pop_front()));
    end
    if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
  end
  initial begin
    int i, c;
    bit acc, stale;
    vt[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vt[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vt[4] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0};
    vt[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};
    #12;
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_sum", longint'(sum), 0);
    chk("rst_flags", longint'({cout, ovf}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rst_in_ready", longint'(in_ready), 1);
    for (int v = 0; v < 7; v++) one($sformatf("vec%0d", v), vt[v].a, vt[v].b, vt[v].ci, 1'b0, vt[v].s, vt[v].co, vt[v].ov);
`ifdef PIPE_ADDER_SUB_EN
    one("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    one("sub_pos", 32'd7, 32'd5, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
`endif
    step();
    collect = 1'b1;
    i = 0;
    c = 0;
    while (got_q.size() < 8 && c < 60) begin
      out_ready = !(c >= 5 && c <= 9);
      in_valid = i < 8;
      a = W'(i); b = W'(i); cin = 1'b0;
      #1;
      if (c >= 5 && c <= 9) chk("bp_in_ready", longint'(in_ready), 0);
      acc = in_valid && in_ready;
      step();
      if (acc) i++;
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    collect = 1'b0;
    chk("bp_count", longint'(got_q.size()), 8);
    for (int j = 0; j < 8 && j < got_q.size(); j++) chk("bp_order", longint'(got_q[j]), longint'(2 * j));
    step();
    for (int j = 0; j < 3; j++) begin
      a = W'(100 + j); b = 32'd1; cin = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("pre_rst_valid", longint'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_valid", longint'(out_valid), 0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", longint'(in_ready), 1);
    stale = 1'b0;
    repeat (6) begin
      step();
      stale |= out_valid;
    end
    chk("no_stale", longint'(stale), 0);
    one("post_rst", 32'h00000010, 32'h00000020, 1'b1, 1'b0, 32'h00000031, 1'b0, 1'b0);
    repeat (300) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(7) == 0) a = 32'hFFFFFFFF;
      if ($urandom_range(7) == 0) b = 32'h80000000;
      cin = 1'($urandom_range(1));
`ifdef PIPE_ADDER_SUB_EN
      sub = 1'($urandom_range(1));
`endif
      in_valid = $urandom_range(3) != 0;
      out_ready = $urandom_range(3) != 0;
      step();
    end
    in_valid = 1'b0;
    sub = 1'b0;
    out_ready = 1'b1;
    repeat (S + 4) step();
    chk("sb_empty", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
